// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite transfer encodings and copy-master state enumeration
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_A,
        WR_D,
        FIN
    } copy_state_t;

endpackage

// File: rtl/ahblite_copy_master.sv
// rtl/ahblite_copy_master.sv - single-word AHB-Lite memory-to-memory copy engine
module ahblite_copy_master
    import ahb_pkg::*;
#(
    parameter int         LEN_W     = 16,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic             HWRITE,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    copy_state_t      state_q;
    copy_state_t      state_d;
    logic [LEN_W-1:0] cnt_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      hold_q;
    logic             err_q;

    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign err       = err_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus outputs decode straight from state so reset clears them without a clock.
    always_comb begin
        state_d = state_q;
        HTRANS  = HTRANS_IDLE;
        HADDR   = '0;
        HWRITE  = 1'b0;
        HWDATA  = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? FIN : RD_A;
                end
            end
            RD_A: begin
                busy   = 1'b1;
                HTRANS = HTRANS_NONSEQ;
                HADDR  = src_q;
                if (HREADY) state_d = RD_D;
            end
            RD_D: begin
                busy = 1'b1;
                if (HREADY) state_d = HRESP ? FIN : WR_A;
            end
            WR_A: begin
                busy   = 1'b1;
                HTRANS = HTRANS_NONSEQ;
                HADDR  = dst_q;
                HWRITE = 1'b1;
                if (HREADY) state_d = WR_D;
            end
            WR_D: begin
                busy   = 1'b1;
                HWDATA = hold_q;
                if (HREADY) begin
                    if (HRESP || cnt_q == LEN_W'(1)) state_d = FIN;
                    else                              state_d = RD_A;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // err latches on the first error cycle; the FSM waits for the HREADY half of the response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q  <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            hold_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q <= {src_addr[31:2], 2'b00};
                        dst_q <= {dst_addr[31:2], 2'b00};
                        cnt_q <= len;
                        err_q <= 1'b0;
                    end
                end
                RD_D: begin
                    if (HRESP)       err_q  <= 1'b1;
                    else if (HREADY) hold_q <= HRDATA;
                end
                WR_D: begin
                    if (HRESP) begin
                        err_q <= 1'b1;
                    end else if (HREADY) begin
                        src_q <= src_q + 32'd4;
                        dst_q <= dst_q + 32'd4;
                        cnt_q <= cnt_q - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahblite_copy_master.sv
// tb/tb_ahblite_copy_master.sv - self-checking bench with a modelled AHB-Lite slave
module tb_ahblite_copy_master;

    logic        HCLK;
    logic        HRESETn;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahblite_copy_master dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    int          cfg_waits;
    int          cfg_err_kind;
    int          cfg_err_idx;
    int          rd_cnt, wr_cnt, rd_iss, wr_iss, nonseq_cnt, hwdata_bad;
    logic [31:0] rd_addr_log [16];
    logic [31:0] wr_addr_log [16];
    logic [31:0] wr_data_log [16];

    logic        dp_act, dp_write, dp_err, dp_err2, dp_first;
    logic [31:0] dp_addr, wd_first;
    int          dp_wait;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Slave model: decides HREADY/HRESP/HRDATA on the falling edge for the coming rising edge.
    initial begin
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        dp_act = 1'b0; dp_write = 1'b0; dp_err = 1'b0; dp_err2 = 1'b0; dp_first = 1'b0;
        dp_addr = '0; wd_first = '0; dp_wait = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                dp_act = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
            end else begin
                HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
                if (dp_act) begin
                    if (!dp_write) HRDATA = mem_word(dp_addr);
                    if (dp_wait > 0) HREADY = 1'b0;
                    else if (dp_err) begin HRESP = 1'b1; HREADY = dp_err2; end
                    if (dp_write) begin
                        if (dp_first) begin wd_first = HWDATA; dp_first = 1'b0; end
                        else if (HWDATA !== wd_first) hwdata_bad++;
                    end
                end
                if (!(dp_act && dp_write) && HWDATA !== 32'h0) hwdata_bad++;
                if (dp_act) begin
                    if (HREADY) begin
                        if (!HRESP) begin
                            if (dp_write) begin
                                if (wr_cnt < 16) begin
                                    wr_addr_log[wr_cnt] = dp_addr;
                                    wr_data_log[wr_cnt] = HWDATA;
                                end
                                wr_cnt++;
                            end else begin
                                if (rd_cnt < 16) rd_addr_log[rd_cnt] = dp_addr;
                                rd_cnt++;
                            end
                        end
                        dp_act = 1'b0;
                    end else if (dp_wait > 0) begin
                        dp_wait--;
                    end else begin
                        dp_err2 = 1'b1;
                    end
                end
                if (HTRANS == 2'b10 && HREADY) begin
                    nonseq_cnt++;
                    dp_act   = 1'b1;
                    dp_write = HWRITE;
                    dp_addr  = HADDR;
                    dp_wait  = cfg_waits;
                    dp_err2  = 1'b0;
                    dp_first = 1'b1;
                    if (HWRITE) begin
                        dp_err = (cfg_err_kind == 2 && wr_iss == cfg_err_idx);
                        wr_iss++;
                    end else begin
                        dp_err = (cfg_err_kind == 1 && rd_iss == cfg_err_idx);
                        rd_iss++;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          waits;
        int          err_kind;
        int          err_idx;
        bit          inject;
        int          exp_fin;
        int          exp_rd;
        int          exp_wr;
        int          exp_nonseq;
        logic        exp_err;
    } vec_t;

    vec_t vt [9];
    logic last_err;

    task automatic clear_logs();
        rd_cnt = 0; wr_cnt = 0; rd_iss = 0; wr_iss = 0; nonseq_cnt = 0; hwdata_bad = 0;
    endtask

    task automatic run_row(input int r, input vec_t v);
        int          cyc;
        logic [31:0] sbase, dbase;
        string       tag;
        tag = $sformatf("row%0d", r);
        clear_logs();
        cfg_waits = v.waits; cfg_err_kind = v.err_kind; cfg_err_idx = v.err_idx;
        check({tag, "_err_sticky"}, {31'd0, err}, {31'd0, last_err});
        start = 1'b1; src_addr = v.src; dst_addr = v.dst; len = 16'(v.len);
        tick();
        start = 1'b0;
        cyc = 1;
        check({tag, "_err_clr"}, {31'd0, err}, 32'd0);
        while (!done && cyc < 300) begin
            if (v.inject && cyc == 2) begin
                start = 1'b1; src_addr = 32'h7000_0000; dst_addr = 32'h7100_0000; len = 16'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_cyc"}, 32'(cyc), 32'(v.exp_fin));
        check({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        repeat (3) tick();
        check({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
        check({tag, "_htrans_idle"}, {30'd0, HTRANS}, 32'd0);
        check({tag, "_nonseq"}, 32'(nonseq_cnt), 32'(v.exp_nonseq));
        check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(v.exp_rd));
        check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(v.exp_wr));
        check({tag, "_hwdata_stable"}, 32'(hwdata_bad), 32'd0);
        sbase = {v.src[31:2], 2'b00};
        dbase = {v.dst[31:2], 2'b00};
        for (int i = 0; i < v.exp_rd && i < rd_cnt && i < 16; i++)
            check($sformatf("%s_rd_addr%0d", tag, i), rd_addr_log[i], sbase + 32'(4 * i));
        for (int i = 0; i < v.exp_wr && i < wr_cnt && i < 16; i++) begin
            check($sformatf("%s_wr_addr%0d", tag, i), wr_addr_log[i], dbase + 32'(4 * i));
            check($sformatf("%s_wr_data%0d", tag, i), wr_data_log[i], mem_word(sbase + 32'(4 * i)));
        end
        last_err = v.exp_err;
    endtask

    initial begin
        int n;
        int snap;
        HRESETn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        cfg_waits = 0; cfg_err_kind = 0; cfg_err_idx = 0; last_err = 1'b0;
        clear_logs();

        //          src           dst           len w  ek ei inj fin rd wr ns err
        vt[0] = '{32'h2000_0000, 32'h2000_0100, 3, 0, 0, 0, 0, 13, 3, 3, 6, 1'b0};
        vt[1] = '{32'h3000_0010, 32'h3000_0800, 1, 2, 0, 0, 0,  9, 1, 1, 2, 1'b0};
        vt[2] = '{32'h3000_0010, 32'h3000_0800, 1, 0, 0, 0, 0,  5, 1, 1, 2, 1'b0};
        vt[3] = '{32'h4000_0000, 32'h4000_1000, 4, 0, 1, 1, 0,  8, 1, 1, 3, 1'b1};
        vt[4] = '{32'h5000_0003, 32'h5000_0102, 2, 1, 0, 0, 0, 13, 2, 2, 4, 1'b0};
        vt[5] = '{32'h1234_5678, 32'h8765_4320, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1'b0};
        vt[6] = '{32'h4400_0000, 32'h4400_0100, 2, 0, 2, 0, 0,  6, 1, 0, 2, 1'b1};
        vt[7] = '{32'hFFFF_FFFC, 32'h0000_0200, 2, 0, 0, 0, 0,  9, 2, 2, 4, 1'b0};
        vt[8] = '{32'h6000_0000, 32'h6000_0400, 2, 0, 0, 0, 1,  9, 2, 2, 4, 1'b0};

        repeat (2) tick();
        check("rst_htrans", {30'd0, HTRANS}, 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("hsize", {29'd0, HSIZE}, 32'd2);
        check("hburst", {29'd0, HBURST}, 32'd0);
        check("hprot", {28'd0, HPROT}, 32'd3);
        check("hmastlock", {31'd0, HMASTLOCK}, 32'd0);
        HRESETn = 1'b1;
        repeat (2) tick();

        for (int r = 0; r < 9; r++) run_row(r, vt[r]);

        clear_logs();
        cfg_waits = 0; cfg_err_kind = 0;
        start = 1'b1; src_addr = 32'hFFFF_FFFC; dst_addr = 32'h0000_0300; len = 16'd2;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
        check("wrap_rd1_addr", rd_addr_log[1], 32'h0000_0000);
        repeat (2) tick();

        clear_logs();
        start = 1'b1; src_addr = 32'h8000_0000; dst_addr = 32'h8000_0100; len = 16'd3;
        tick();
        start = 1'b0;
        n = 0;
        while (!(HTRANS == 2'b10 && HWRITE) && n < 20) begin tick(); n++; end
        check("reach_wr_a", 32'(n < 20), 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("mid_rst_htrans", {30'd0, HTRANS}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_haddr", HADDR, 32'd0);
        check("mid_rst_hwrite", {31'd0, HWRITE}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        tick();
        HRESETn = 1'b1;
        snap = nonseq_cnt;
        repeat (6) tick();
        check("no_resume_nonseq", 32'(nonseq_cnt), 32'(snap));
        check("no_resume_busy", {31'd0, busy}, 32'd0);
        check("no_resume_hwdata", HWDATA, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
